// File: rtl/ramulator_port_arbiter.sv
// Round-robin arbiter sharing the Ramulator request port among N_REQ requesters,
// with retry on reject and an address-indexed read table for routing completions.
module ramulator_port_arbiter #(
    parameter int N_REQ           = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      up_req_valid,
    input  logic [N_REQ*64-1:0]   up_req_addr,
    input  logic [N_REQ-1:0]      up_req_type,
    input  logic [N_REQ*64-1:0]   up_req_data,
    output logic [N_REQ-1:0]      up_req_ready,
    output logic [N_REQ-1:0]      up_resp_valid,
    output logic [63:0]           up_resp_addr,
    output logic [63:0]           up_resp_data,
    output logic                  mem_req_valid,
    output logic [63:0]           mem_req_addr,
    output logic                  mem_req_type,
    output logic [31:0]           mem_req_source_id,
    output logic [63:0]           mem_req_data,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [63:0]           mem_resp_addr,
    input  logic [63:0]           mem_resp_data,
    input  logic                  mem_init_done,
    output logic [5:0]            outstanding,
    output logic                  err_unmatched
);

    localparam int IDW = $clog2(N_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]                 state;
    logic [IDW-1:0]             rr_ptr;
    logic [IDW-1:0]             hold_id;
    logic [63:0]                hold_addr;
    logic [63:0]                hold_data;
    logic                       hold_type;

    logic [MAX_OUTSTANDING-1:0] tbl_valid;
    logic [63:0]                tbl_addr [MAX_OUTSTANDING];
    logic [IDW-1:0]             tbl_rid  [MAX_OUTSTANDING];

    logic [N_REQ-1:0]           hazard;
    logic [N_REQ-1:0]           eligible;
    logic                       tbl_full;
    logic                       grant_found;
    logic [IDW-1:0]             grant_idx;
    logic [63:0]                sel_addr;
    logic [63:0]                sel_data;
    logic                       sel_type;
    logic [MAX_OUTSTANDING-1:0] alloc_sel;
    logic                       alloc_found;
    logic [MAX_OUTSTANDING-1:0] resp_hit;
    logic [N_REQ-1:0]           resp_onehot;
    logic                       accept;

    // An address already in the table blocks reads and writes alike.
    always_comb begin
        hazard = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            for (int unsigned k = 0; k < MAX_OUTSTANDING; k++) begin
                if (tbl_valid[k] && (tbl_addr[k] == up_req_addr[64*i +: 64])) begin
                    hazard[i] = 1'b1;
                end
            end
        end
    end

    assign tbl_full = &tbl_valid;
    assign eligible = up_req_valid & ~hazard & (up_req_type | {N_REQ{~tbl_full}});

    // Circular search split in two passes: indices >= rr_ptr first, then the wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!grant_found && eligible[i] && (IDW'(i) >= rr_ptr)) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(i);
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!grant_found && eligible[i]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(i);
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_type = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_addr = up_req_addr[64*i +: 64];
                sel_data = up_req_data[64*i +: 64];
                sel_type = up_req_type[i];
            end
        end
    end

    always_comb begin
        alloc_sel   = '0;
        alloc_found = 1'b0;
        for (int unsigned k = 0; k < MAX_OUTSTANDING; k++) begin
            if (!alloc_found && !tbl_valid[k]) begin
                alloc_sel[k] = 1'b1;
                alloc_found  = 1'b1;
            end
        end
    end

    always_comb begin
        resp_hit    = '0;
        resp_onehot = '0;
        for (int unsigned k = 0; k < MAX_OUTSTANDING; k++) begin
            if (mem_resp_valid && tbl_valid[k] && (tbl_addr[k] == mem_resp_addr)) begin
                resp_hit[k] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            for (int unsigned k = 0; k < MAX_OUTSTANDING; k++) begin
                if (resp_hit[k] && (tbl_rid[k] == IDW'(i))) begin
                    resp_onehot[i] = 1'b1;
                end
            end
        end
    end

    assign accept = (state == ST_WAIT) && mem_req_ready;

    always_comb begin
        up_req_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            up_req_ready[i] = accept && (hold_id == IDW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            hold_id   <= '0;
            hold_addr <= '0;
            hold_data <= '0;
            hold_type <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_init_done && grant_found) begin
                        hold_id   <= grant_idx;
                        hold_addr <= sel_addr;
                        hold_data <= sel_data;
                        hold_type <= sel_type;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (mem_req_ready) begin
                        rr_ptr <= (hold_id == IDW'(N_REQ - 1)) ? '0 : hold_id + IDW'(1);
                        state  <= ST_IDLE;
                    end else begin
                        state  <= ST_ISSUE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Allocation picks from the pre-release free vector, so it never collides with a release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_valid <= '0;
            for (int unsigned k = 0; k < MAX_OUTSTANDING; k++) begin
                tbl_addr[k] <= '0;
                tbl_rid[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < MAX_OUTSTANDING; k++) begin
                if (resp_hit[k]) begin
                    tbl_valid[k] <= 1'b0;
                end
                if (accept && !hold_type && alloc_sel[k]) begin
                    tbl_valid[k] <= 1'b1;
                    tbl_addr[k]  <= hold_addr;
                    tbl_rid[k]   <= hold_id;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_resp_valid <= '0;
            up_resp_addr  <= '0;
            up_resp_data  <= '0;
            err_unmatched <= 1'b0;
        end else begin
            up_resp_valid <= resp_onehot;
            if (|resp_hit) begin
                up_resp_addr <= mem_resp_addr;
                up_resp_data <= mem_resp_data;
            end
            if (mem_resp_valid && !(|resp_hit)) begin
                err_unmatched <= 1'b1;
            end
        end
    end

    always_comb begin
        outstanding = '0;
        for (int unsigned k = 0; k < MAX_OUTSTANDING; k++) begin
            outstanding = outstanding + 6'(tbl_valid[k]);
        end
    end

    assign mem_req_valid     = (state == ST_ISSUE);
    assign mem_req_addr      = hold_addr;
    assign mem_req_type      = hold_type;
    assign mem_req_data      = hold_data;
    assign mem_req_source_id = 32'(hold_id);

endmodule
